// File: rtl/vga_timing_ctrl_if.sv
// CPU bus port of the VGA timing controller: a single write strobe plus a
// combinational read-back of the pending color register.
interface vga_timing_ctrl_if;
  logic [63:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr,
    output bus_we,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_we,
    input  bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// 640x480 VGA timing generator with a SCALE-down logical pixel grid and a
// frame-synchronous color register written over the CPU bus.
package configurations;
  localparam logic [63:0] VGA_BASE_ADDR   = 64'h0000_0000_2000_0008;
  localparam int          SCALE_FACTOR    = 5;
  localparam logic [9:0]  H_MAX           = 10'd831;
  localparam logic [9:0]  H_VISIBLE       = 10'd640;
  localparam logic [9:0]  START_H_RETRACE = 10'd664;
  localparam logic [9:0]  END_H_RETRACE   = 10'd703;
  localparam logic [9:0]  V_MAX           = 10'd518;
  localparam logic [9:0]  V_VISIBLE       = 10'd480;
  localparam logic [9:0]  START_V_RETRACE = 10'd508;
  localparam logic [9:0]  END_V_RETRACE   = 10'd510;
endpackage

module vga_timing_ctrl #(
  parameter logic [63:0] BASE_ADDR       = configurations::VGA_BASE_ADDR,
  parameter int          SCALE           = configurations::SCALE_FACTOR,
  parameter logic [9:0]  H_MAX           = configurations::H_MAX,
  parameter logic [9:0]  H_VISIBLE       = configurations::H_VISIBLE,
  parameter logic [9:0]  START_H_RETRACE = configurations::START_H_RETRACE,
  parameter logic [9:0]  END_H_RETRACE   = configurations::END_H_RETRACE,
  parameter logic [9:0]  V_MAX           = configurations::V_MAX,
  parameter logic [9:0]  V_VISIBLE       = configurations::V_VISIBLE,
  parameter logic [9:0]  START_V_RETRACE = configurations::START_V_RETRACE,
  parameter logic [9:0]  END_V_RETRACE   = configurations::END_V_RETRACE
) (
  input  logic                    clock,
  input  logic                    reset,
  vga_timing_ctrl_if.slave        bus,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    disp_en,
  output logic [6:0]              pix_x,
  output logic [6:0]              pix_y,
  output logic                    frame_start,
  output logic [11:0]             rgb
);

  localparam int             SW       = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SW-1:0]  SUB_LAST = SW'(SCALE - 1);

  logic [9:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [SW-1:0] hs_cnt_q, hs_cnt_d, vs_cnt_q, vs_cnt_d;
  logic [6:0]    x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [11:0]   pending_color_q, pending_color_d;
  logic [11:0]   active_color_q, active_color_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          disp_en_q, disp_en_d, frame_start_q, frame_start_d;
  logic [6:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [11:0]   rgb_q, rgb_d;

  logic h_wrap_s, v_wrap_s, frame_origin_s, visible_s, bus_hit_s;

  assign h_wrap_s       = (h_cnt_q == H_MAX);
  assign v_wrap_s       = h_wrap_s && (v_cnt_q == V_MAX);
  assign frame_origin_s = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  assign visible_s      = (h_cnt_q < H_VISIBLE) && (v_cnt_q < V_VISIBLE);
  assign bus_hit_s      = (bus.bus_addr == BASE_ADDR);

  assign bus.bus_rdata = bus_hit_s ? {20'd0, pending_color_q} : 32'd0;

  // Raster position counters and the scaled logical-pixel counters.
  always_comb begin
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    hs_cnt_d = hs_cnt_q;
    x_cnt_d  = x_cnt_q;
    vs_cnt_d = vs_cnt_q;
    y_cnt_d  = y_cnt_q;

    if (h_wrap_s) begin
      h_cnt_d = 10'd0;
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    if (v_wrap_s) begin
      v_cnt_d = 10'd0;
    end else if (h_wrap_s) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end

    // x keeps counting through blanking; pix_x only samples it while visible.
    if (h_wrap_s) begin
      hs_cnt_d = {SW{1'b0}};
      x_cnt_d  = 7'd0;
    end else if (hs_cnt_q == SUB_LAST) begin
      hs_cnt_d = {SW{1'b0}};
      x_cnt_d  = x_cnt_q + 7'd1;
    end else begin
      hs_cnt_d = hs_cnt_q + SW'(1);
      x_cnt_d  = x_cnt_q;
    end

    if (v_wrap_s) begin
      vs_cnt_d = {SW{1'b0}};
      y_cnt_d  = 7'd0;
    end else if (h_wrap_s) begin
      if (vs_cnt_q == SUB_LAST) begin
        vs_cnt_d = {SW{1'b0}};
        y_cnt_d  = y_cnt_q + 7'd1;
      end else begin
        vs_cnt_d = vs_cnt_q + SW'(1);
        y_cnt_d  = y_cnt_q;
      end
    end else begin
      vs_cnt_d = vs_cnt_q;
      y_cnt_d  = y_cnt_q;
    end
  end

  // Color registers: the bus writes pending, the frame origin promotes it.
  always_comb begin
    pending_color_d = pending_color_q;
    active_color_d  = active_color_q;

    if (bus.bus_we && bus_hit_s) begin
      pending_color_d = bus.bus_wdata[11:0];
    end else begin
      pending_color_d = pending_color_q;
    end

    if (frame_origin_s) begin
      active_color_d = pending_color_q;
    end else begin
      active_color_d = active_color_q;
    end
  end

  // Video outputs decoded from the current raster position.
  always_comb begin
    hsync_d       = !((h_cnt_q >= START_H_RETRACE) && (h_cnt_q <= END_H_RETRACE));
    vsync_d       = !((v_cnt_q >= START_V_RETRACE) && (v_cnt_q <= END_V_RETRACE));
    disp_en_d     = visible_s;
    frame_start_d = frame_origin_s;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    rgb_d         = 12'd0;

    // Use the promoted color so the first pixel of a frame already shows it.
    if (visible_s) begin
      pix_x_d = x_cnt_q;
      pix_y_d = y_cnt_q;
      rgb_d   = active_color_d;
    end else begin
      pix_x_d = pix_x_q;
      pix_y_d = pix_y_q;
      rgb_d   = 12'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt_q         <= 10'd0;
      v_cnt_q         <= 10'd0;
      hs_cnt_q        <= {SW{1'b0}};
      vs_cnt_q        <= {SW{1'b0}};
      x_cnt_q         <= 7'd0;
      y_cnt_q         <= 7'd0;
      pending_color_q <= 12'd0;
      active_color_q  <= 12'd0;
      hsync_q         <= 1'b1;
      vsync_q         <= 1'b1;
      disp_en_q       <= 1'b0;
      frame_start_q   <= 1'b0;
      pix_x_q         <= 7'd0;
      pix_y_q         <= 7'd0;
      rgb_q           <= 12'd0;
    end else begin
      h_cnt_q         <= h_cnt_d;
      v_cnt_q         <= v_cnt_d;
      hs_cnt_q        <= hs_cnt_d;
      vs_cnt_q        <= vs_cnt_d;
      x_cnt_q         <= x_cnt_d;
      y_cnt_q         <= y_cnt_d;
      pending_color_q <= pending_color_d;
      active_color_q  <= active_color_d;
      hsync_q         <= hsync_d;
      vsync_q         <= vsync_d;
      disp_en_q       <= disp_en_d;
      frame_start_q   <= frame_start_d;
      pix_x_q         <= pix_x_d;
      pix_y_q         <= pix_y_d;
      rgb_q           <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign disp_en     = disp_en_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_q;

endmodule
